// File: rtl/ticket_counter_multi.sv
// ticket_counter_multi: multi-destination ticket counter with saturating credit, refund and greedy change
module ticket_counter_multi #(
  parameter int NUM_DEST   = 8,
  parameter int DEST_W     = 3,
  parameter int FARE_BASE  = 150,
  parameter int FARE_STEP  = 40,
  parameter int MAX_QTY    = 4,
  parameter int CREDIT_W   = 11,
  parameter int MAX_CREDIT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_inserted,
  input  logic [1:0]          coin_value,
  input  logic                ticket_selected,
  input  logic [DEST_W-1:0]   ticket_destination,
  input  logic [2:0]          ticket_qty,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                ticket_dispensed,
  output logic [DEST_W-1:0]   ticket_dest,
  output logic                change_returned,
  output logic [1:0]          change_value,
  output logic                coin_reject,
  output logic                select_error,
  output logic                insufficient,
  output logic [15:0]         tickets_sold
);
  localparam int TW = CREDIT_W + 4;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_e;
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, chg_amt;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [2:0] rem_q, rem_d;
  logic [15:0] sold_q, sold_d;
  logic [1:0] cv_q, cv_d, chg_code;
  logic disp_q, disp_d, chg_q, chg_d, rej_q, rej_d, serr_q, serr_d, ins_q, ins_d, busy_q;
  logic [CREDIT_W:0] coin_sum;
  logic [TW-1:0] total;
  logic sel_bad;
  function automatic logic [CREDIT_W:0] coin_jpy(input logic [1:0] c);
    return (CREDIT_W+1)'(c == 2'd3 ? 500 : c == 2'd2 ? 100 : c == 2'd1 ? 50 : 10);
  endfunction
  assign coin_sum = {1'b0, credit_q} + coin_jpy(coin_value);
  assign total = (TW'(FARE_BASE) + TW'(FARE_STEP) * TW'(ticket_destination)) * TW'(ticket_qty);
  assign sel_bad = 32'(ticket_destination) >= NUM_DEST || ticket_qty == 3'd0 || 32'(ticket_qty) > MAX_QTY;
  // largest coin not exceeding the remaining credit
  assign chg_code = {1'b0, credit_q} >= coin_jpy(2'd3) ? 2'd3 :
                    {1'b0, credit_q} >= coin_jpy(2'd2) ? 2'd2 :
                    {1'b0, credit_q} >= coin_jpy(2'd1) ? 2'd1 : 2'd0;
  assign chg_amt = CREDIT_W'(coin_jpy(chg_code));
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    dest_d   = dest_q;
    rem_d    = rem_q;
    sold_d   = sold_q;
    cv_d     = cv_q;
    disp_d   = 1'b0;
    chg_d    = 1'b0;
    rej_d    = 1'b0;
    serr_d   = 1'b0;
    ins_d    = 1'b0;
    case (state_q)
      S_DISPENSE: begin
        disp_d  = 1'b1;
        sold_d  = sold_q + {15'd0, sold_q != 16'hFFFF};
        rem_d   = rem_q - 3'd1;
        state_d = rem_q != 3'd1 ? S_DISPENSE : credit_q != '0 ? S_CHANGE : S_IDLE;
        rej_d   = coin_inserted;
        serr_d  = ticket_selected;
      end
      S_CHANGE: begin
        chg_d    = 1'b1;
        cv_d     = chg_code;
        credit_d = credit_q - chg_amt;
        state_d  = credit_q == chg_amt ? S_IDLE : S_CHANGE;
        rej_d    = coin_inserted;
        serr_d   = ticket_selected;
      end
      default: begin
        if (cancel) begin
          state_d = credit_q != '0 ? S_CHANGE : state_q;
        end else if (coin_inserted) begin
          serr_d = ticket_selected;
          if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end else if (ticket_selected) begin
          if (sel_bad) begin
            serr_d = 1'b1;
          end else if (TW'(credit_q) < total) begin
            ins_d = 1'b1;
          end else begin
            credit_d = credit_q - CREDIT_W'(total);
            dest_d   = ticket_destination;
            rem_d    = ticket_qty;
            state_d  = S_DISPENSE;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      dest_q   <= '0;
      rem_q    <= '0;
      sold_q   <= '0;
      cv_q     <= '0;
      disp_q   <= 1'b0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      serr_q   <= 1'b0;
      ins_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dest_q   <= dest_d;
      rem_q    <= rem_d;
      sold_q   <= sold_d;
      cv_q     <= cv_d;
      disp_q   <= disp_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      serr_q   <= serr_d;
      ins_q    <= ins_d;
      busy_q   <= state_d == S_DISPENSE || state_d == S_CHANGE;
    end
  end
  assign credit           = credit_q;
  assign busy             = busy_q;
  assign ticket_dispensed = disp_q;
  assign ticket_dest      = dest_q;
  assign change_returned  = chg_q;
  assign change_value     = cv_q;
  assign coin_reject      = rej_q;
  assign select_error     = serr_q;
  assign insufficient     = ins_q;
  assign tickets_sold     = sold_q;
endmodule

// File: doc/ticket_counter_multi.md
Name: ticket_counter_multi

Overview:
Parametrised self-service ticket counter. It is the successor to the single-ticket vending machine. It adds:
- N destinations with an arithmetic fare table
- multi-ticket purchase
- credit saturation
- cancel/refund
- multi-cycle greedy change dispensing, one coin per cycle

It sits between the coin acceptor and the ticket printer / change hopper.

Parameters:
- NUM_DEST, 8: number of valid destinations, 0..NUM_DEST-1.
- DEST_W, 3: width of the destination field. Must satisfy 2**DEST_W >= NUM_DEST.
- FARE_BASE, 150: fare of destination 0, in JPY. Must be a multiple of 10.
- FARE_STEP, 40: fare increment per destination index, in JPY. Must be a multiple of 10.
- MAX_QTY, 4: maximum tickets per purchase.
- CREDIT_W, 11: width of the credit register.
- MAX_CREDIT, 1000: credit ceiling, in JPY. Must satisfy MAX_CREDIT < 2**CREDIT_W.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- coin_inserted, in, 1: one-cycle coin strobe.
- coin_value, in, 2: coin code. 00=10, 01=50, 10=100, 11=500 JPY.
- ticket_selected, in, 1: one-cycle purchase strobe.
- ticket_destination, in, DEST_W: destination index.
- ticket_qty, in, 3: tickets requested.
- cancel, in, 1: one-cycle refund request.
- credit, out, CREDIT_W: current credit in JPY.
- busy, out, 1: high in DISPENSE and CHANGE.
- ticket_dispensed, out, 1: one pulse per ticket.
- ticket_dest, out, DEST_W: destination of the current ticket.
- change_returned, out, 1: one pulse per change coin.
- change_value, out, 2: coin code of the change coin, same encoding as coin_value.
- coin_reject, out, 1: pulse when a coin is refused.
- select_error, out, 1: pulse when a selection is invalid.
- insufficient, out, 1: pulse when credit is less than the total fare.
- tickets_sold, out, 16: saturating count of all tickets dispensed.

Behaviour:

Reset:
- While reset is low, asynchronously: state=IDLE, credit=0, tickets_sold=0, all pulse outputs 0, ticket_dest=0, change_value=00.
- Reset mid-purchase or mid-change discards the remaining credit with no refund.

Timing:
- All outputs are registered.
- A flag responds in the cycle after its input strobe is sampled.
- Pulse outputs are high for exactly one cycle.

Fare arithmetic:
- fare = FARE_BASE + FARE_STEP*dest.
- total = fare*qty.
- Compute at CREDIT_W+4 bits; no truncation.

State IDLE and COLLECT (IDLE means credit == 0), priority per cycle:
1. cancel:
   - credit > 0: go to CHANGE (full refund).
   - credit == 0: no effect.
   - Any coin or select in the same cycle is ignored. No flags are raised.
2. coin_inserted:
   - credit + value <= MAX_CREDIT: credit += value.
   - Otherwise: coin_reject pulses and credit is unchanged.
   - A ticket_selected in the same cycle is dropped and select_error pulses.
3. ticket_selected, checked in this order:
   - dest >= NUM_DEST, qty == 0 or qty > MAX_QTY: select_error pulses; stay in state.
   - credit < total: insufficient pulses; credit is retained.
   - Otherwise: credit -= total, latch dest and qty, go to DISPENSE.

State DISPENSE:
- ticket_dispensed pulses on qty consecutive cycles, starting the cycle after entry.
- ticket_dest holds the latched dest throughout.
- tickets_sold increments per ticket and saturates at 16'hFFFF.
- After the last ticket: credit > 0 goes to CHANGE; credit == 0 goes to IDLE.

State CHANGE:
- Each cycle, emit the largest coin <= credit, in the order 500, 100, 50, 10.
- change_returned pulses, change_value carries the coin code, and credit decreases by the coin value.
- When credit reaches 0, go to IDLE on the next cycle.
- Credit is always a multiple of 10, so change always terminates exactly.

Inputs while busy:
- coin_inserted: coin_reject pulses; credit is unchanged.
- ticket_selected: select_error pulses.
- cancel: ignored.

Invariant: credit <= MAX_CREDIT at all times.

Test Plan:
- Insert 100, then 100 (credit=200); select dest=1, qty=1 (fare 190) -> credit=10, one ticket_dispensed with ticket_dest=1, then one change_returned with change_value=00; end in IDLE, tickets_sold=1.
- Insert 500; select dest=0, qty=3 (total 450) -> three consecutive ticket_dispensed pulses, then one change coin with code 01 (50); credit=0; tickets_sold increments by 3.
- Insert 50; select dest=3 (fare 270) -> insufficient pulse, credit stays 50. Then cancel -> change code 01 once, IDLE, no tickets.
- Insert 500, then 500 (credit=1000); insert 10 -> coin_reject, credit=1000. Select qty=5 -> select_error. Select dest=7, qty=0 -> select_error. Cancel -> two change coins of code 11 (500 each).
- Same-cycle coin 100 and select dest 0 from credit 100 -> credit=200, select_error, no ticket. Coin inserted during DISPENSE -> coin_reject, credit unchanged.
- Insert 500; select dest=0, qty=1 (change 350, emitted as 100, 100, 100, 50); assert reset after the second change coin -> credit, tickets_sold and all outputs are 0 immediately; the counter accepts a coin normally after reset is released.
